timer_irq_servicer: RTL

//  Avalon-MM master (initiator) that drives the 16-bit-data interval-timer slave.
//  On start: writes the period, then writes control to start the timer.
//  On each timer irq: clears status, latches a snapshot, reads it back, counts the tick.

---
 rtl/timer_irq_servicer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/timer_irq_servicer.sv
// Avalon-MM master that programs the interval timer and services its irq.
// Each timeout: clear status, latch snapshot, read it back, count the tick.
module timer_irq_servicer #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_cont,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              timer_irq,
    output logic              busy,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [TICK_W-1:0] tick_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTL,
        S_WAIT,
        S_CLR,
        S_SNAPW,
        S_RDL,
        S_RDH,
        S_RDDONE,
        S_WR_STOP
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [31:0] period_q;
    logic        cont_q;
    logic        stop_pend;
    logic        stop_req;

    logic        cs_d;
    logic        wn_d;
    logic [2:0]  addr_d;
    logic [15:0] wd_d;

    // A stop pulse arriving in the deciding cycle is honoured at once.
    assign stop_req = stop_pend | stop;
    assign busy     = (state != S_IDLE);

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:    if (start) nxt = S_WR_PL;
            S_WR_PL:   nxt = S_WR_PH;
            S_WR_PH:   nxt = S_WR_CTL;
            S_WR_CTL:  nxt = S_WAIT;
            S_WAIT: begin
                if (stop_req)       nxt = S_WR_STOP;
                else if (timer_irq) nxt = S_CLR;
            end
            S_CLR:     nxt = S_SNAPW;
            S_SNAPW:   nxt = S_RDL;
            S_RDL:     nxt = S_RDH;
            S_RDH:     nxt = S_RDDONE;
            S_RDDONE: begin
                if (stop_req)    nxt = S_WR_STOP;
                else if (cont_q) nxt = S_WAIT;
                else             nxt = S_IDLE;
            end
            S_WR_STOP: nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Bus signals are decoded from the next state so they register in step.
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = 3'd0;
        wd_d   = 16'h0000;
        unique case (nxt)
            S_WR_PL: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 3'd2;
                wd_d   = cfg_period[15:0];
            end
            S_WR_PH: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 3'd3;
                wd_d   = period_q[31:16];
            end
            S_WR_CTL: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 3'd1;
                wd_d   = {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
            end
            S_CLR: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 3'd0;
            end
            S_SNAPW: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 3'd4;
            end
            S_RDL: begin
                cs_d   = 1'b1;
                addr_d = 3'd4;
            end
            S_RDH: begin
                cs_d   = 1'b1;
                addr_d = 3'd5;
            end
            S_WR_STOP: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 3'd1;
                wd_d   = 16'h0008;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 3'd0;
            m_writedata  <= 16'h0000;
        end else begin
            state        <= nxt;
            m_chipselect <= cs_d;
            m_write_n    <= wn_d;
            m_address    <= addr_d;
            m_writedata  <= wd_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= 32'h0;
            cont_q   <= 1'b0;
        end else if (state == S_IDLE && start) begin
            period_q <= cfg_period;
            cont_q   <= cfg_cont;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_pend <= 1'b0;
        end else if (state == S_WR_STOP) begin
            stop_pend <= 1'b0;
        end else if (stop && state != S_IDLE) begin
            stop_pend <= 1'b1;
        end
    end

    // Readdata lags the address by one cycle: low half in RDH, high in RDDONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_value <= 32'h0;
            snap_valid <= 1'b0;
            tick_count <= '0;
        end else begin
            snap_valid <= (nxt == S_RDDONE);
            if (state == S_RDH) begin
                snap_value[15:0] <= m_readdata;
            end
            if (state == S_RDDONE) begin
                snap_value[31:16] <= m_readdata;
                tick_count        <= tick_count + 1'b1;
            end
        end
    end

endmodule
